// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: shared types and constants for the AHB-to-APB4 bridge on decoder slave port s1
package ahb_apb_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE, ST_ERR1, ST_ERR2} state_t;
   localparam logic [1:0] HRESP_OKAY = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;
   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;
   localparam logic [39:0] S1_BASE = 40'h00_1f00_0000;
   localparam logic [39:0] S1_END = 40'h00_1f01_ffff;
endpackage

// File: rtl/ahb_apb_lane.sv
// ahb_apb_lane: byte strobes, 32-bit lane extraction/placement and size/alignment check
module ahb_apb_lane import ahb_apb_pkg::*; (
   input  logic [1:0]   i_addr,
   input  logic [2:0]   i_size,
   input  logic [1:0]   i_lane,
   input  logic [127:0] i_hwdata,
   input  logic [31:0]  i_prdata,
   output logic [3:0]   o_strb,
   output logic [31:0]  o_wdata,
   output logic [127:0] o_rdata,
   output logic         o_err
);
   // strobes and error from the live address phase, lanes from the registered lane index
   always_comb begin
      o_strb = i_size == HSIZE_WORD ? 4'hf : i_size == HSIZE_HALF ? 4'b0011 << i_addr : 4'b0001 << i_addr;
      o_err = i_size > HSIZE_WORD || (i_size == HSIZE_HALF && i_addr[0]) || (i_size == HSIZE_WORD && i_addr != 2'b00);
      o_wdata = i_hwdata[{i_lane, 5'b0} +: 32];
      o_rdata = {96'b0, i_prdata} << {i_lane, 5'b0};
   end
endmodule

// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: one 32-bit APB4 transfer per selected 128-bit AHB transfer, with two-cycle ERROR
module ahb_apb_bridge import ahb_apb_pkg::*; #(
   parameter int PADDR_W = 32
) (
   input  logic               pll_core_cpuclk,
   input  logic               pad_cpu_rst_b,
   input  logic               hsel,
   input  logic [39:0]        haddr,
   input  logic [1:0]         htrans,
   input  logic               hwrite,
   input  logic [2:0]         hsize,
   input  logic [2:0]         hburst,
   input  logic [3:0]         hprot,
   input  logic [127:0]       hwdata,
   output logic [127:0]       hrdata,
   output logic               hready,
   output logic [1:0]         hresp,
   output logic               psel,
   output logic               penable,
   output logic               pwrite,
   output logic [PADDR_W-1:0] paddr,
   output logic [31:0]        pwdata,
   output logic [3:0]         pstrb,
   output logic [2:0]         pprot,
   input  logic [31:0]        prdata,
   input  logic               pready,
   input  logic               pslverr
);
   state_t               r_state;
   logic [1:0]           r_lane;
   logic [127:0]         r_hrdata;
   logic                 r_hready;
   logic [1:0]           r_hresp;
   logic                 r_psel;
   logic                 r_penable;
   logic                 r_pwrite;
   logic [PADDR_W-1:0]   r_paddr;
   logic [31:0]          r_pwdata;
   logic [3:0]           r_pstrb;
   logic [2:0]           r_pprot;
   logic                 w_accept;
   logic                 w_err;
   logic [3:0]           w_strb;
   logic [31:0]          w_wdata;
   logic [127:0]         w_rdata;
   logic                 w_unused;

   ahb_apb_lane u_lane (
      .i_addr   (haddr[1:0]),
      .i_size   (hsize),
      .i_lane   (r_lane),
      .i_hwdata (hwdata),
      .i_prdata (prdata),
      .o_strb   (w_strb),
      .o_wdata  (w_wdata),
      .o_rdata  (w_rdata),
      .o_err    (w_err)
   );

   assign w_accept = hsel && htrans[1] && (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_unused = ^{haddr, htrans[0], hburst, hprot[3:2]};
   assign hrdata = r_hrdata;
   assign hready = r_hready;
   assign hresp = r_hresp;
   assign psel = r_psel;
   assign penable = r_penable;
   assign pwrite = r_pwrite;
   assign paddr = r_paddr;
   assign pstrb = r_pstrb;
   assign pprot = r_pprot;
   // hwdata only arrives in the data phase, so SETUP forwards the lane before it is held
   assign pwdata = (r_state == ST_SETUP && r_pwrite) ? w_wdata : r_pwdata;

   // bridge FSM with registered AHB and APB outputs
   always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         r_state <= ST_IDLE;
         r_lane <= '0;
         r_hrdata <= '0;
         r_hready <= 1'b1;
         r_hresp <= HRESP_OKAY;
         r_psel <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite <= 1'b0;
         r_paddr <= '0;
         r_pwdata <= '0;
         r_pstrb <= '0;
         r_pprot <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_hrdata <= '0;
               r_hresp <= HRESP_OKAY;
               if (w_accept && w_err) begin
                  r_state <= ST_ERR1;
                  r_hready <= 1'b0;
                  r_hresp <= HRESP_ERROR;
               end else if (w_accept) begin
                  r_state <= ST_SETUP;
                  r_hready <= 1'b0;
                  r_psel <= 1'b1;
                  r_lane <= haddr[3:2];
                  r_pwrite <= hwrite;
                  r_paddr <= haddr[PADDR_W-1:0];
                  r_pstrb <= hwrite ? w_strb : 4'b0;
                  r_pprot <= {~hprot[0], 1'b0, hprot[1]};
               end else begin
                  r_state <= ST_IDLE;
                  r_hready <= 1'b1;
               end
            end
            ST_SETUP: begin
               r_state <= ST_ACCESS;
               r_penable <= 1'b1;
               if (r_pwrite) r_pwdata <= w_wdata;
            end
            ST_ACCESS: begin
               if (pready) begin
                  r_psel <= 1'b0;
                  r_penable <= 1'b0;
                  if (pslverr) begin
                     r_state <= ST_ERR1;
                     r_hresp <= HRESP_ERROR;
                  end else begin
                     r_state <= ST_DONE;
                     r_hready <= 1'b1;
                     r_hrdata <= r_pwrite ? 128'b0 : w_rdata;
                  end
               end
            end
            ST_ERR1: begin
               r_state <= ST_ERR2;
               r_hready <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_hready <= 1'b1;
               r_hresp <= HRESP_OKAY;
               r_hrdata <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb_ahb_apb_bridge: directed AHB/APB vectors checked by a queue-based scoreboard monitor
module tb_ahb_apb_bridge;
   import ahb_apb_pkg::*;

   typedef struct {
      logic [1:0]   resp;
      logic [127:0] data;
      int           lat;
   } ahb_exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
   } apb_exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic hsel, hwrite, hready, psel, penable, pwrite, pready, pslverr;
   logic [39:0] haddr;
   logic [1:0] htrans, hresp;
   logic [2:0] hsize, hburst, pprot;
   logic [3:0] hprot, pstrb;
   logic [127:0] hwdata, hrdata;
   logic [31:0] paddr, pwdata, prdata;

   ahb_exp_t ahb_q[$];
   apb_exp_t apb_q[$];
   ahb_exp_t me;
   apb_exp_t ma;
   int vectors = 0;
   int miscompares = 0;
   int s_wait = 0;
   int s_cnt = 0;
   logic s_err = 1'b0;
   logic [31:0] s_rdata = '0;
   logic dphase = 1'b0;
   int lat = 0;
   logic prev_hready = 1'b1;
   logic [1:0] prev_hresp = 2'b0;
   logic prev_wait = 1'b0;
   logic [73:0] snap = '0;

   ahb_apb_bridge #(.PADDR_W(32)) dut (
      .pll_core_cpuclk (clk),
      .pad_cpu_rst_b   (rst_n),
      .hsel            (hsel),
      .haddr           (haddr),
      .htrans          (htrans),
      .hwrite          (hwrite),
      .hsize           (hsize),
      .hburst          (hburst),
      .hprot           (hprot),
      .hwdata          (hwdata),
      .hrdata          (hrdata),
      .hready          (hready),
      .hresp           (hresp),
      .psel            (psel),
      .penable         (penable),
      .pwrite          (pwrite),
      .paddr           (paddr),
      .pwdata          (pwdata),
      .pstrb           (pstrb),
      .pprot           (pprot),
      .prdata          (prdata),
      .pready          (pready),
      .pslverr         (pslverr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic exp_ahb(input logic [1:0] resp, input logic [127:0] data, input int l);
      ahb_exp_t e;
      e.resp = resp;
      e.data = data;
      e.lat = l;
      ahb_q.push_back(e);
   endtask

   task automatic exp_apb(input logic [31:0] a, input logic wr, input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
      apb_exp_t e;
      e.addr = a;
      e.wr = wr;
      e.wdata = wd;
      e.strb = st;
      e.prot = pr;
      apb_q.push_back(e);
   endtask

   task automatic issue(input logic [39:0] a, input logic wr, input logic [2:0] sz, input logic [3:0] pr, input logic [127:0] wd, input logic idle_after);
      bit ok = 0;
      hsel = 1'b1;
      htrans = 2'b10;
      haddr = a;
      hwrite = wr;
      hsize = sz;
      hprot = pr;
      hburst = 3'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (hready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: hready low for 50 cycles, expected high");
      end
      @(posedge clk);
      #1;
      hwdata = wd;
      if (idle_after) begin
         hsel = 1'b0;
         htrans = 2'b00;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ahb_q.size() == 0) break;
      end
      if (ahb_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL resp_timeout: %0d responses outstanding, expected 0", ahb_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   // APB slave: pready after s_wait access cycles, pslverr on the completing cycle
   initial begin
      pready = 1'b0;
      pslverr = 1'b0;
      prdata = '0;
      forever begin
         @(posedge clk);
         #1;
         prdata = s_rdata;
         if (psel && penable) begin
            pready = (s_cnt == s_wait);
            pslverr = (s_cnt == s_wait) && s_err;
            s_cnt++;
         end else begin
            pready = 1'b0;
            pslverr = 1'b0;
            s_cnt = 0;
         end
      end
   end

   // monitor: pops expectations whenever the DUT completes an APB transfer or an AHB data phase
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            dphase = 1'b0;
            prev_wait = 1'b0;
         end else begin
            if (prev_wait) chk("apb_hold", {psel, penable, pwrite, paddr, pwdata, pstrb, pprot}, snap);
            prev_wait = psel && penable && !pready;
            snap = {psel, penable, pwrite, paddr, pwdata, pstrb, pprot};
            if (psel && !penable) begin
               vectors++;
               if (apb_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL apb_unexpected: psel with paddr %0h, expected no transfer", paddr);
               end
            end
            if (psel && penable && pready && apb_q.size() > 0) begin
               ma = apb_q.pop_front();
               chk("paddr", paddr, ma.addr);
               chk("pwrite", pwrite, ma.wr);
               chk("pstrb", pstrb, ma.strb);
               chk("pprot", pprot, ma.prot);
               if (ma.wr) chk("pwdata", pwdata, ma.wdata);
            end
            if (dphase) lat++;
            if (dphase && hready) begin
               if (ahb_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL ahb_unexpected: response %0h, expected none", hresp);
               end else begin
                  me = ahb_q.pop_front();
                  chk("hresp", hresp, me.resp);
                  chk("hrdata", hrdata, me.data);
                  chk("latency", lat, me.lat);
                  if (me.resp == HRESP_ERROR) chk("err_first_cycle", {prev_hready, prev_hresp}, {1'b0, HRESP_ERROR});
               end
               dphase = 1'b0;
            end
            if (hready && hsel && htrans[1]) begin
               dphase = 1'b1;
               lat = 0;
            end
            prev_hready = hready;
            prev_hresp = hresp;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      bit seen = 0;
      hsel = 1'b0;
      htrans = 2'b00;
      haddr = '0;
      hwrite = 1'b0;
      hsize = 3'b0;
      hburst = 3'b0;
      hprot = 4'b0;
      hwdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_hready", hready, 1'b1);
      chk("rst_hresp", hresp, HRESP_OKAY);
      chk("rst_hrdata", hrdata, 128'b0);
      chk("rst_apb", {psel, penable, pwrite, paddr, pwdata, pstrb, pprot}, 74'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      s_rdata = 32'hdeadbeef;
      exp_apb(32'h1f000008, 1'b0, 32'h0, 4'b0000, 3'b001);
      exp_ahb(HRESP_OKAY, {32'h0, 32'hdeadbeef, 64'h0}, 3);
      issue(40'h1f000008, 1'b0, HSIZE_WORD, 4'b0011, 128'h0, 1'b1);
      wait_idle();

      s_wait = 2;
      exp_apb(32'h1f000017, 1'b1, 32'haabbccdd, 4'b1000, 3'b100);
      exp_ahb(HRESP_OKAY, 128'h0, 5);
      issue(40'h1f000017, 1'b1, HSIZE_BYTE, 4'b0000, {32'h44444444, 32'h33333333, 32'haabbccdd, 32'h11111111}, 1'b1);
      wait_idle();

      s_wait = 0;
      exp_ahb(HRESP_ERROR, 128'h0, 2);
      issue(40'h1f000002, 1'b0, HSIZE_WORD, 4'b0011, 128'h0, 1'b1);
      wait_idle();
      exp_ahb(HRESP_ERROR, 128'h0, 2);
      issue(40'h1f000010, 1'b1, 3'd3, 4'b0011, 128'h0, 1'b1);
      wait_idle();
      exp_ahb(HRESP_ERROR, 128'h0, 2);
      issue(40'h1f000001, 1'b0, HSIZE_HALF, 4'b0011, 128'h0, 1'b1);
      wait_idle();

      s_err = 1'b1;
      s_rdata = 32'h0badf00d;
      exp_apb(32'h1f000004, 1'b0, 32'h0, 4'b0000, 3'b101);
      exp_ahb(HRESP_ERROR, 128'h0, 4);
      issue(40'h1f000004, 1'b0, HSIZE_WORD, 4'b0010, 128'h0, 1'b1);
      wait_idle();
      s_err = 1'b0;

      s_wait = 1;
      exp_apb(32'h1f000006, 1'b1, 32'hbeef1234, 4'b1100, 3'b001);
      exp_ahb(HRESP_OKAY, 128'h0, 4);
      issue(40'h1f000006, 1'b1, HSIZE_HALF, 4'b0011, {32'h0, 32'h0, 32'hbeef1234, 32'h5555aaaa}, 1'b1);
      wait_idle();

      s_wait = 0;
      s_rdata = 32'h00ab0000;
      exp_apb(32'h1f00000d, 1'b0, 32'h0, 4'b0000, 3'b001);
      exp_ahb(HRESP_OKAY, {32'h00ab0000, 96'h0}, 3);
      issue(40'h1f00000d, 1'b0, HSIZE_BYTE, 4'b0011, 128'h0, 1'b1);
      wait_idle();

      exp_apb(32'h1f010000, 1'b1, 32'h01020304, 4'b1111, 3'b001);
      exp_apb(32'h1f01000c, 1'b1, 32'hcafef00d, 4'b1111, 3'b001);
      exp_ahb(HRESP_OKAY, 128'h0, 3);
      exp_ahb(HRESP_OKAY, 128'h0, 3);
      issue(40'h1f010000, 1'b1, HSIZE_WORD, 4'b0011, {32'h77777777, 32'h66666666, 32'h55555555, 32'h01020304}, 1'b0);
      issue(40'h1f01000c, 1'b1, HSIZE_WORD, 4'b0011, {32'hcafef00d, 32'h99999999, 32'h88888888, 32'h12121212}, 1'b1);
      wait_idle();

      s_wait = 10;
      s_rdata = 32'h12345678;
      exp_apb(32'h1f00000c, 1'b0, 32'h0, 4'b0000, 3'b001);
      exp_ahb(HRESP_OKAY, {32'h12345678, 96'h0}, 13);
      issue(40'h1f00000c, 1'b0, HSIZE_WORD, 4'b0011, 128'h0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (psel && penable) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL access_timeout: no ACCESS phase seen, expected one");
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_psel", psel, 1'b0);
      chk("async_rst_penable", penable, 1'b0);
      chk("async_rst_hready", hready, 1'b1);
      chk("async_rst_hrdata", hrdata, 128'b0);
      chk("async_rst_hresp", hresp, HRESP_OKAY);
      apb_q.delete();
      ahb_q.delete();
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      s_wait = 0;
      exp_apb(32'h1f00000c, 1'b0, 32'h0, 4'b0000, 3'b001);
      exp_ahb(HRESP_OKAY, {32'h12345678, 96'h0}, 3);
      issue(40'h1f00000c, 1'b0, HSIZE_WORD, 4'b0011, 128'h0, 1'b1);
      wait_idle();

      repeat (3) @(negedge clk);
      chk("queues_drained", apb_q.size() + ahb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
